contador_arbitro: RTL and testbench

- Shares the single read port of the four-word FIFO counter block (req/idx in, valid_contador/contador_out back) between NUM_REQ requesters, e.g. the prober and a status/debug agent.
- Arbitrates round-robin and issues read requests only while the datapath reports IDLE.
- Captures the returned 5-bit count and routes it back to the winning requester with a one-cycle valid pulse.

---
 rtl/contador_pkg.sv | 16 +
 rtl/contador_arbitro_rr.sv | 34 +++
 rtl/contador_arbitro.sv | 140 ++++++++++++++
 tb/tb_contador_arbitro.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared types and constants for the counter-port arbiter slice.
package contador_pkg;

    localparam int NUM_CONTADORES = 4;
    localparam int CNT_W          = 5;
    localparam int IDX_W          = 2;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        ARB       = 3'd1,
        ISSUE     = 3'd2,
        WAIT_RESP = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/contador_arbitro_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbitro #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             any
);

    logic found;

    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/contador_arbitro.sv
// Shares the counter block's read port between NUM_REQ requesters, round-robin.
// Define CONTADOR_ARB_TIMEOUT_EN to abort reads with no response after TIMEOUT cycles.
module contador_arbitro #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 2,
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [NUM_REQ-1:0]       req_in,
    input  logic [NUM_REQ*IDX_W-1:0] idx_in,
    input  logic                     IDLE,
    input  logic                     valid_contador,
    input  logic [CNT_W-1:0]         contador_in,
    output logic                     req_out,
    output logic [IDX_W-1:0]         idx_out,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [CNT_W-1:0]         data_out,
    output logic [NUM_REQ-1:0]       valid_out,
    output logic                     err_out,
    output logic                     busy
);
    import contador_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt_num;
    logic [PTR_W-1:0]   sel_num;
    logic [NUM_REQ-1:0] gnt_c;
    logic               any_c;
    logic [IDX_W-1:0]   sel_idx;

`ifdef CONTADOR_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] tcnt;
`endif

    rr_arbitro #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req (req_in),
        .ptr (ptr),
        .gnt (gnt_c),
        .any (any_c)
    );

    always_comb begin
        sel_idx = '0;
        sel_num = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt_c[j]) begin
                sel_idx = idx_in[j*IDX_W +: IDX_W];
                sel_num = PTR_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state     <= WAIT_IDLE;
            ptr       <= '0;
            gnt_num   <= '0;
            req_out   <= 1'b0;
            idx_out   <= '0;
            gnt       <= '0;
            data_out  <= '0;
            valid_out <= '0;
            err_out   <= 1'b0;
            busy      <= 1'b0;
`ifdef CONTADOR_ARB_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            case (state)
                WAIT_IDLE: if (IDLE && |req_in) state <= ARB;
                ARB: begin
                    if (IDLE && any_c) begin
                        gnt     <= gnt_c;
                        idx_out <= sel_idx;
                        gnt_num <= sel_num;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end else begin
                        state   <= WAIT_IDLE;
                    end
                end
                ISSUE: begin
                    if (IDLE) begin
                        req_out <= 1'b1;
                        state   <= WAIT_RESP;
`ifdef CONTADOR_ARB_TIMEOUT_EN
                        tcnt    <= '0;
`endif
                    end else begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        state   <= WAIT_IDLE;
                    end
                end
                WAIT_RESP: begin
                    req_out <= 1'b0;
                    // While req_out is still high the response is not back yet;
                    // a valid seen then is left over from an earlier read.
                    if (!req_out && valid_contador) begin
                        data_out  <= contador_in;
                        valid_out <= gnt;
                        state     <= DONE;
                    end
`ifdef CONTADOR_ARB_TIMEOUT_EN
                    else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                        data_out  <= '0;
                        valid_out <= gnt;
                        err_out   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    valid_out <= '0;
                    err_out   <= 1'b0;
                    gnt       <= '0;
                    busy      <= 1'b0;
                    ptr       <= (gnt_num == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_num + 1'b1;
                    state     <= WAIT_IDLE;
                end
                default: begin
                    state     <= WAIT_IDLE;
                    req_out   <= 1'b0;
                    gnt       <= '0;
                    valid_out <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_contador_arbitro.sv
// Randomized self-checking bench for contador_arbitro with a registered counter-block model.
module tb_contador_arbitro;

    localparam int NUM_REQ = 2;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 5;
    localparam int TIMEOUT = 4;

    logic                     clk;
    logic                     reset_L;
    logic [NUM_REQ-1:0]       req_in;
    logic [NUM_REQ*IDX_W-1:0] idx_in;
    logic                     IDLE;
    logic                     valid_contador;
    logic [CNT_W-1:0]         contador_in;
    logic                     req_out;
    logic [IDX_W-1:0]         idx_out;
    logic [NUM_REQ-1:0]       gnt;
    logic [CNT_W-1:0]         data_out;
    logic [NUM_REQ-1:0]       valid_out;
    logic                     err_out;
    logic                     busy;

    int checks = 0;
    int failures = 0;
    int ptr_m = 0;
    logic [CNT_W-1:0] last_data = '0;
    logic [CNT_W-1:0] mem [4];
    bit resp_en = 1'b1;

    contador_arbitro #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_L(reset_L), .req_in(req_in), .idx_in(idx_in), .IDLE(IDLE),
        .valid_contador(valid_contador), .contador_in(contador_in), .req_out(req_out),
        .idx_out(idx_out), .gnt(gnt), .data_out(data_out), .valid_out(valid_out),
        .err_out(err_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter block: registers its answer, valid stays high until the next read or reset.
    always @(posedge clk) begin
        if (!reset_L) begin
            valid_contador <= 1'b0;
            contador_in    <= '0;
        end else if (!resp_en) begin
            valid_contador <= 1'b0;
        end else if (req_out) begin
            valid_contador <= 1'b1;
            contador_in    <= mem[idx_out];
        end
    end

    function automatic int pick(logic [NUM_REQ-1:0] r, int p);
        for (int k = 0; k < NUM_REQ; k++)
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic do_reset();
        reset_L = 1'b0;
        req_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
        ptr_m   = 0;
    endtask

    // Waits for the next valid_out; c-1 is the cycle count from the first sampling edge.
    task automatic run_txn(output bit got, output int t_req, output int t_val,
                           output logic [IDX_W-1:0] i_req, output logic [NUM_REQ-1:0] g_req);
        got = 1'b0; t_req = -1; t_val = -1; i_req = '0; g_req = '0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk);
            #1;
            if (req_out) begin t_req = c - 1; i_req = idx_out; g_req = gnt; end
            if (|valid_out) begin got = 1'b1; t_val = c - 1; end
        end
    endtask

    task automatic test_reset();
        reset_L = 1'b0; req_in = 2'b11; IDLE = 1'b1; idx_in = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({req_out, idx_out, gnt, data_out, valid_out, err_out, busy} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got req=%b idx=%0d gnt=%b data=%0d vld=%b err=%b busy=%b, want all 0",
                         c, req_out, idx_out, gnt, data_out, valid_out, err_out, busy);
            end
        end
        req_in = '0;
        #0 reset_L = 1'b1;
    endtask

    task automatic test_single();
        bit got; int tr, tv; logic [IDX_W-1:0] ir; logic [NUM_REQ-1:0] gr;
        do_reset();
        mem[2] = 5'd9;
        idx_in[0*IDX_W +: IDX_W] = 2'd2;
        req_in = 2'b01;
        run_txn(got, tr, tv, ir, gr);
        checks++; if (!got) begin failures++; $display("FAIL single_done: no valid_out within 20 cycles"); end
        checks++; if (tr !== 2) begin failures++; $display("FAIL single_req_lat: got %0d want 2", tr); end
        checks++; if (ir !== 2'd2) begin failures++; $display("FAIL single_idx_out: got %0d want 2", ir); end
        checks++; if (tv !== 4) begin failures++; $display("FAIL single_vld_lat: got %0d want 4", tv); end
        checks++; if (valid_out !== 2'b01) begin failures++; $display("FAIL single_valid_out: got %b want 01", valid_out); end
        checks++; if (data_out !== 5'd9) begin failures++; $display("FAIL single_data: got %0d want 9", data_out); end
        last_data = 5'd9; ptr_m = 1;
        req_in = '0;
        @(posedge clk); #1;
        checks++; if ({valid_out, gnt, busy} !== '0) begin failures++; $display("FAIL single_after: got vld=%b gnt=%b busy=%b want 0", valid_out, gnt, busy); end
    endtask

    task automatic test_contention();
        bit got; int tr, tv, w; logic [IDX_W-1:0] ir; logic [NUM_REQ-1:0] gr, want;
        logic [CNT_W-1:0] exp_d;
        do_reset();
        mem[0] = 5'd3; mem[3] = 5'd17;
        idx_in = {2'd3, 2'd0};
        req_in = 2'b11;
        for (int k = 0; k < 3; k++) begin
            w = pick(req_in, ptr_m);
            want = '0; want[w] = 1'b1;
            exp_d = mem[idx_in[w*IDX_W +: IDX_W]];
            run_txn(got, tr, tv, ir, gr);
            checks++;
            if (!got || valid_out !== want || data_out !== exp_d) begin
                failures++;
                $display("FAIL contention_%0d: got vld=%b data=%0d want vld=%b data=%0d", k, valid_out, data_out, want, exp_d);
            end
            last_data = exp_d; ptr_m = (w + 1) % NUM_REQ;
        end
        req_in = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_gating();
        bit got; int tr, tv; logic [IDX_W-1:0] ir; logic [NUM_REQ-1:0] gr;
        logic [CNT_W-1:0] v;
        v = CNT_W'($urandom);
        mem[1] = v;
        IDLE = 1'b0;
        idx_in[0*IDX_W +: IDX_W] = 2'd1;
        req_in = 2'b01;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (req_out !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_gate_hold cycle %0d: got req_out=%b busy=%b want 0 0", c, req_out, busy);
            end
        end
        IDLE = 1'b1;
        run_txn(got, tr, tv, ir, gr);
        checks++;
        if (!got || valid_out !== 2'b01 || data_out !== v) begin
            failures++;
            $display("FAIL idle_gate_read: got vld=%b data=%0d want 01 %0d", valid_out, data_out, v);
        end
        last_data = v; ptr_m = 1;
        req_in = '0;
        @(posedge clk); #1;
        // Abort in ISSUE by requester 1; a wrongly advanced pointer would favour requester 0 next.
        idx_in[1*IDX_W +: IDX_W] = 2'd2;
        req_in = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 2'b10 || busy !== 1'b1) begin
            failures++;
            $display("FAIL issue_grant: got gnt=%b busy=%b want 10 1", gnt, busy);
        end
        IDLE = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({req_out, gnt, busy, valid_out} !== '0) begin
                failures++;
                $display("FAIL issue_abort cycle %0d: got req=%b gnt=%b busy=%b vld=%b want 0", c, req_out, gnt, busy, valid_out);
            end
        end
        mem[2] = 5'd21; mem[0] = 5'd4;
        idx_in[0*IDX_W +: IDX_W] = 2'd0;
        req_in = 2'b11; IDLE = 1'b1;
        run_txn(got, tr, tv, ir, gr);
        checks++;
        if (!got || valid_out !== 2'b10 || data_out !== 5'd21) begin
            failures++;
            $display("FAIL ptr_unchanged: got vld=%b data=%0d want 10 21", valid_out, data_out);
        end
        last_data = 5'd21; ptr_m = 0;
        req_in = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_stale_valid();
        logic [CNT_W-1:0] nv;
        nv = ~last_data;
        mem[3] = nv;
        idx_in[0*IDX_W +: IDX_W] = 2'd3;
        req_in = 2'b01;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c < 5) begin
                checks++;
                if (valid_out !== 2'b00 || data_out !== last_data) begin
                    failures++;
                    $display("FAIL stale_early cycle %0d: got vld=%b data=%0d want 00 %0d", c - 1, valid_out, data_out, last_data);
                end
            end else begin
                checks++;
                if (valid_out !== 2'b01 || data_out !== nv) begin
                    failures++;
                    $display("FAIL stale_capture: got vld=%b data=%0d want 01 %0d", valid_out, data_out, nv);
                end
            end
        end
        last_data = nv; ptr_m = 1;
        req_in = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_random_rr();
        bit got; int tr, tv, w; logic [IDX_W-1:0] ir; logic [NUM_REQ-1:0] gr, want;
        logic [CNT_W-1:0] exp_d;
        do_reset();
        for (int it = 0; it < 16; it++) begin
            for (int m = 0; m < 4; m++) mem[m] = CNT_W'($urandom);
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!req_in[r] && $urandom_range(0, 1) == 1) begin
                    idx_in[r*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 3));
                    req_in[r] = 1'b1;
                end
            end
            if (req_in == '0) begin
                idx_in[0*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 3));
                req_in[0] = 1'b1;
            end
            w = pick(req_in, ptr_m);
            want = '0; want[w] = 1'b1;
            exp_d = mem[idx_in[w*IDX_W +: IDX_W]];
            run_txn(got, tr, tv, ir, gr);
            checks++;
            if (!got || valid_out !== want || data_out !== exp_d || err_out !== 1'b0 ||
                gr !== want || ir !== idx_in[w*IDX_W +: IDX_W]) begin
                failures++;
                $display("FAIL random_%0d: got vld=%b data=%0d err=%b gnt=%b idx=%0d want vld=%b data=%0d err=0 idx=%0d",
                         it, valid_out, data_out, err_out, gr, ir, want, exp_d, idx_in[w*IDX_W +: IDX_W]);
            end
            ptr_m = (w + 1) % NUM_REQ;
            req_in[w] = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (valid_out !== '0 || gnt !== '0) begin
                failures++;
                $display("FAIL random_pulse_%0d: got vld=%b gnt=%b want 00 00", it, valid_out, gnt);
            end
        end
        req_in = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        resp_en = 1'b0;
        idx_in[0*IDX_W +: IDX_W] = 2'd1;
        req_in = 2'b01;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b want 1", busy); end
        do_reset();
        resp_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (valid_out !== '0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_abandon cycle %0d: got vld=%b busy=%b want 00 0", c, valid_out, busy);
            end
        end
    endtask

    task automatic test_timeout();
`ifdef CONTADOR_ARB_TIMEOUT_EN
        bit got; int tr, tv; logic [IDX_W-1:0] ir; logic [NUM_REQ-1:0] gr;
        do_reset();
        resp_en = 1'b0;
        idx_in[1*IDX_W +: IDX_W] = 2'd2;
        req_in = 2'b10;
        run_txn(got, tr, tv, ir, gr);
        checks++;
        if (!got || tv !== 2 + TIMEOUT || valid_out !== 2'b10 || err_out !== 1'b1 || data_out !== '0) begin
            failures++;
            $display("FAIL timeout: got lat=%0d vld=%b err=%b data=%0d want lat=%0d vld=10 err=1 data=0",
                     tv, valid_out, err_out, data_out, 2 + TIMEOUT);
        end
        req_in = '0;
        @(posedge clk); #1;
        checks++;
        if (err_out !== 1'b0 || valid_out !== '0) begin
            failures++;
            $display("FAIL timeout_pulse: got err=%b vld=%b want 0 00", err_out, valid_out);
        end
        resp_en = 1'b1;
`else
        resp_en = 1'b0;
        idx_in[0*IDX_W +: IDX_W] = 2'd0;
        req_in = 2'b01;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            checks++;
            if (valid_out !== '0 || err_out !== 1'b0) begin
                failures++;
                $display("FAIL no_timeout cycle %0d: got vld=%b err=%b want 00 0", c, valid_out, err_out);
            end
        end
        do_reset();
        resp_en = 1'b1;
`endif
    endtask

    initial begin
        reset_L = 1'b0; req_in = '0; idx_in = '0; IDLE = 1'b1;
        for (int m = 0; m < 4; m++) mem[m] = '0;
        test_reset();
        test_single();
        test_contention();
        test_idle_gating();
        test_stale_valid();
        test_random_rr();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
